// File: rtl/logger_pkg.sv
// rtl/logger_pkg.sv - shared state encoding and sizing constants for buff_reader
// BUFF_READER_CSUM_EN adds the CSUM state to the encoding.
package logger_pkg;

  localparam int BLOCK_LEN_MAX = 256;
  localparam int ADDR_W        = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
`ifdef BUFF_READER_CSUM_EN
    CSUM  = 3'd4,
`endif
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/buff_reader.sv
// rtl/buff_reader.sv - streams one full buffer half per write_done as a byte stream
// BUFF_READER_CSUM_EN appends a modulo-256 checksum byte to every block.
module buff_reader
  import logger_pkg::*;
#(
  parameter int BLOCK_LEN = 256,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_pulse,
  input  logic              write_done,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [7:0]        din,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              block_done,
  output logic              overrun
);

  localparam int                LEN      = (BLOCK_LEN > BLOCK_LEN_MAX) ? BLOCK_LEN_MAX : BLOCK_LEN;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LEN - 1);
  localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lat_cnt;
  logic              pending;
  logic              hs;
  logic              last_byte;
  logic              lat_done;
  logic              start_blk;
`ifdef BUFF_READER_CSUM_EN
  logic [7:0]        csum;
`endif

  assign hs         = tx_valid & tx_ready;
  assign last_byte  = (idx == LAST_IDX);
  assign lat_done   = (lat_cnt == LAT_LAST);
  assign start_blk  = (state == IDLE) & (pending | write_done) & ~start_pulse;
  // The index register only moves on entry to FETCH, so it doubles as the held read address.
  assign read_addr  = idx;
  assign block_done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start_pulse) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start_blk) state_nxt = FETCH;
        FETCH: state_nxt = WAIT;
        WAIT:  if (lat_done) state_nxt = SEND;
        SEND: begin
          if (hs) begin
            if (last_byte) begin
`ifdef BUFF_READER_CSUM_EN
              state_nxt = CSUM;
`else
              state_nxt = DONE;
`endif
            end else begin
              state_nxt = FETCH;
            end
          end
        end
`ifdef BUFF_READER_CSUM_EN
        CSUM:  if (hs) state_nxt = DONE;
`endif
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      lat_cnt <= '0;
    end else begin
      lat_cnt <= (state == WAIT && !lat_done) ? lat_cnt + 2'd1 : 2'd0;
      if (start_blk) begin
        idx <= '0;
      end else if (state == SEND && hs && !last_byte && !start_pulse) begin
        idx <= idx + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (start_pulse) begin
      tx_valid <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (lat_done) begin
            tx_data  <= din;
            tx_valid <= 1'b1;
          end
        end
        SEND: begin
          if (hs) begin
`ifdef BUFF_READER_CSUM_EN
            // The checksum byte follows the last data byte with tx_valid kept high.
            if (last_byte) begin
              tx_data <= csum + tx_data;
            end else begin
              tx_valid <= 1'b0;
            end
`else
            tx_valid <= 1'b0;
`endif
          end
        end
`ifdef BUFF_READER_CSUM_EN
        CSUM: if (hs) tx_valid <= 1'b0;
`endif
        default: ;
      endcase
    end
  end

`ifdef BUFF_READER_CSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if (start_blk) begin
      csum <= '0;
    end else if (state == SEND && hs) begin
      csum <= csum + tx_data;
    end
  end
`endif

  // Only one block can wait behind the one being read; a further write_done loses data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (start_pulse) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (write_done) begin
      if (pending) overrun <= 1'b1;
      pending <= ~((state == IDLE) & ~pending);
    end else if (state == IDLE && pending) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_buff_reader.sv
// tb/tb_buff_reader.sv - randomized self-checking bench for buff_reader
// BUFF_READER_CSUM_EN enables the checksum byte expectations.
module tb_buff_reader;

  localparam int BL = 256;
  localparam int RL = 1;
`ifdef BUFF_READER_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int BYTES = BL + CS;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_pulse = 1'b0;
  logic       write_done = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] read_addr;
  logic [7:0] din;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       block_done;
  logic       overrun;

  buff_reader #(.BLOCK_LEN(BL), .RD_LAT(RL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_pulse(start_pulse),
    .write_done (write_done),
    .read_addr  (read_addr),
    .din        (din),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .block_done (block_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous buffer with RL cycles of read latency.
  logic [7:0] mem [BL];
  logic [7:0] addr_pipe [RL];
  always @(posedge clk) begin
    addr_pipe[0] <= read_addr;
    for (int i = 1; i < RL; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign din = mem[addr_pipe[RL-1]];

  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got[$];
  int         hs_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         stab_err = 0;
  bit         stall_prev = 0;
  logic [7:0] data_prev = '0;

  always @(negedge clk) begin
    if (reset) begin
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        hs_cyc.push_back(cyc);
      end
      if (block_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_prev && !(tx_valid && tx_data == data_prev)) stab_err++;
    end
    stall_prev = reset && tx_valid && !tx_ready && !start_pulse;
    data_prev  = tx_data;
  end

  int         passed = 0;
  int         total = 0;
  int         ready_pct = 100;
  int         inj[$];
  bit         inj_last = 0;
  logic [7:0] exp_q[$];

  task automatic build_exp(input int nblk);
    for (int b = 0; b < nblk; b++) begin
      int s = 0;
      for (int i = 0; i < BL; i++) begin
        exp_q.push_back(mem[i]);
        s += int'(mem[i]);
      end
      if (CS != 0) exp_q.push_back(8'(s % 256));
    end
  endtask

  function automatic int stream_diffs();
    int d = 0;
    if (got.size() != exp_q.size()) d++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic new_session();
    @(posedge clk); #1;
    start_pulse = 1; tx_ready = 0; write_done = 0;
    @(posedge clk); #1;
    start_pulse = 0;
    repeat (2) @(posedge clk);
    #1;
    got.delete(); hs_cyc.delete(); exp_q.delete();
    done_cnt = 0; stab_err = 0; inj.delete(); inj_last = 0;
  endtask

  task automatic run(input int n_done, input int stop_bytes, input int budget, input string tag);
    int t = 0;
    while (!(done_cnt >= n_done || (stop_bytes > 0 && got.size() >= stop_bytes)) && t < budget) begin
      @(posedge clk); #1;
      write_done = 0;
      tx_ready = ($urandom_range(99) < ready_pct);
      if (inj.size() > 0 && got.size() >= inj[0]) begin
        write_done = 1;
        void'(inj.pop_front());
      end else if (inj_last && tx_valid && read_addr == 8'(BL - 1)) begin
        write_done = 1;
        inj_last = 0;
      end
      t++;
    end
    total++;
    if (t >= budget) $display("FAIL %s_timeout: done=%0d bytes=%0d required done=%0d bytes=%0d", tag, done_cnt, got.size(), n_done, stop_bytes);
    else passed++;
    @(posedge clk); #1;
    write_done = 0;
  endtask

  task automatic test_reset();
    bit seen = 0;
    #12;
    total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data); else passed++;
    total++; if (read_addr !== 8'h00) $display("FAIL reset_read_addr: got %h expected 00", read_addr); else passed++;
    total++; if (block_done !== 1'b0) $display("FAIL reset_block_done: got %b expected 0", block_done); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
    @(posedge clk); #1;
    reset = 1; tx_ready = 1;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) seen = 1;
    end
    total++; if (seen) $display("FAIL reset_release_valid: got tx_valid=1 expected 0"); else passed++;
  endtask

  task automatic test_single_block();
    int span, last_hs;
    new_session();
    for (int i = 0; i < BL; i++) mem[i] = 8'(i) ^ 8'h5A;
    ready_pct = 100; inj = '{0};
    build_exp(1);
    run(1, 0, 3000, "single");
    repeat (10) @(posedge clk);
    #1;
    span    = (hs_cyc.size() >= BYTES) ? hs_cyc[BL-1] - hs_cyc[0] : -1;
    last_hs = (hs_cyc.size() >= BYTES) ? hs_cyc[BYTES-1] : -1;
    total++; if (stream_diffs() != 0) $display("FAIL single_stream: %0d diffs, got %0d bytes expected %0d", stream_diffs(), got.size(), exp_q.size()); else passed++;
    total++; if (done_cnt != 1) $display("FAIL single_done_count: got %0d expected 1", done_cnt); else passed++;
    total++; if (span != (BL - 1) * (RL + 2)) $display("FAIL single_throughput: got %0d cycles expected %0d", span, (BL - 1) * (RL + 2)); else passed++;
    total++; if (done_cyc != last_hs + 1) $display("FAIL single_done_timing: got cycle %0d expected %0d", done_cyc, last_hs + 1); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL single_overrun: got %b expected 0", overrun); else passed++;
  endtask

  task automatic test_random_ready();
    new_session();
    for (int i = 0; i < BL; i++) mem[i] = 8'($urandom);
    ready_pct = 30; inj = '{0};
    build_exp(1);
    run(1, 0, 10000, "random");
    total++; if (stream_diffs() != 0) $display("FAIL random_stream: %0d diffs, got %0d bytes expected %0d", stream_diffs(), got.size(), exp_q.size()); else passed++;
    total++; if (stab_err != 0) $display("FAIL random_stability: got %0d unstable stalls expected 0", stab_err); else passed++;
    total++; if (done_cnt != 1) $display("FAIL random_done_count: got %0d expected 1", done_cnt); else passed++;
    ready_pct = 100;
  endtask

  task automatic test_back_to_back();
    int gap;
    new_session();
    for (int i = 0; i < BL; i++) mem[i] = 8'(i) ^ 8'h5A;
    ready_pct = 100; inj = '{0, 50};
    build_exp(2);
    run(2, 0, 6000, "b2b");
    gap = (hs_cyc.size() > BYTES) ? hs_cyc[BYTES] - hs_cyc[BYTES-1] : -1;
    total++; if (stream_diffs() != 0) $display("FAIL b2b_stream: %0d diffs, got %0d bytes expected %0d", stream_diffs(), got.size(), exp_q.size()); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b expected 0", overrun); else passed++;
    total++; if (gap != RL + 4) $display("FAIL b2b_gap: got %0d cycles expected %0d", gap, RL + 4); else passed++;
  endtask

  task automatic test_overrun();
    new_session();
    for (int i = 0; i < BL; i++) mem[i] = 8'($urandom);
    ready_pct = 100; inj = '{0, 50, 60};
    build_exp(2);
    run(2, 0, 6000, "overrun");
    repeat (1000) @(posedge clk);
    #1;
    total++; if (overrun !== 1'b1) $display("FAIL overrun_flag: got %b expected 1", overrun); else passed++;
    total++; if (done_cnt != 2) $display("FAIL overrun_done_count: got %0d expected 2", done_cnt); else passed++;
    total++; if (stream_diffs() != 0) $display("FAIL overrun_stream: %0d diffs, got %0d bytes expected %0d", stream_diffs(), got.size(), exp_q.size()); else passed++;
  endtask

  task automatic test_final_handshake();
    new_session();
    for (int i = 0; i < BL; i++) mem[i] = 8'(i) ^ 8'h5A;
    ready_pct = 100; inj = '{0}; inj_last = 1;
    build_exp(2);
    run(2, 0, 6000, "final_hs");
    total++; if (stream_diffs() != 0) $display("FAIL final_hs_stream: %0d diffs, got %0d bytes expected %0d", stream_diffs(), got.size(), exp_q.size()); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL final_hs_overrun: got %b expected 0", overrun); else passed++;
  endtask

  task automatic test_start_abort();
    int n0;
    new_session();
    for (int i = 0; i < BL; i++) mem[i] = 8'(i) ^ 8'h5A;
    ready_pct = 100; inj = '{0, 10, 20};
    run(99, 100, 2000, "abort_run");
    total++; if (overrun !== 1'b1) $display("FAIL abort_pre_overrun: got %b expected 1", overrun); else passed++;
    start_pulse = 1; write_done = 1; tx_ready = 0;
    @(posedge clk); #1;
    start_pulse = 0; write_done = 0;
    total++; if (tx_valid !== 1'b0) $display("FAIL abort_tx_valid: got %b expected 0", tx_valid); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL abort_overrun: got %b expected 0", overrun); else passed++;
    n0 = got.size();
    tx_ready = 1;
    repeat (800) @(posedge clk);
    #1;
    total++; if (got.size() != n0) $display("FAIL abort_idle_bytes: got %0d bytes expected %0d", got.size(), n0); else passed++;
    total++; if (done_cnt != 0) $display("FAIL abort_idle_done: got %0d expected 0", done_cnt); else passed++;
    got.delete(); hs_cyc.delete(); exp_q.delete();
    build_exp(1);
    write_done = 1;
    @(posedge clk); #1;
    write_done = 0;
    total++; if (read_addr !== 8'h00) $display("FAIL abort_restart_addr: got %h expected 00", read_addr); else passed++;
    run(1, 0, 3000, "abort_restart");
    total++; if (stream_diffs() != 0) $display("FAIL abort_restart_stream: %0d diffs, got %0d bytes expected %0d", stream_diffs(), got.size(), exp_q.size()); else passed++;
  endtask

`ifdef BUFF_READER_CSUM_EN
  task automatic test_csum();
    logic [7:0] c;
    new_session();
    for (int i = 0; i < BL; i++) mem[i] = 8'h01;
    ready_pct = 100; inj = '{0};
    run(1, 0, 3000, "csum_ones");
    c = (got.size() > BL) ? got[BL] : 8'hxx;
    total++; if (c !== 8'h00) $display("FAIL csum_ones: got %h expected 00", c); else passed++;
    new_session();
    for (int i = 0; i < BL; i++) mem[i] = 8'(i);
    inj = '{0};
    run(1, 0, 3000, "csum_addr");
    c = (got.size() > BL) ? got[BL] : 8'hxx;
    total++; if (c !== 8'h80) $display("FAIL csum_addr: got %h expected 80", c); else passed++;
  endtask
`endif

  task automatic test_async_reset();
    int t = 0;
    new_session();
    for (int i = 0; i < BL; i++) mem[i] = 8'(i) ^ 8'h5A;
    ready_pct = 100; inj = '{0, 1, 2};
    run(9, 4, 2000, "async_run");
    tx_ready = 0; ready_pct = 0;
    while (!tx_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    total++; if (!(tx_valid && overrun && read_addr != 8'h00)) $display("FAIL async_setup: got valid=%b overrun=%b addr=%h expected 1 1 nonzero", tx_valid, overrun, read_addr); else passed++;
    @(negedge clk); #2;
    reset = 0;
    #1;
    total++; if (tx_valid !== 1'b0) $display("FAIL async_tx_valid: got %b expected 0", tx_valid); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL async_tx_data: got %h expected 00", tx_data); else passed++;
    total++; if (read_addr !== 8'h00) $display("FAIL async_read_addr: got %h expected 00", read_addr); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL async_overrun: got %b expected 0", overrun); else passed++;
    total++; if (block_done !== 1'b0) $display("FAIL async_block_done: got %b expected 0", block_done); else passed++;
    @(posedge clk); #1;
    reset = 1; tx_ready = 1; ready_pct = 100;
    got.delete(); done_cnt = 0;
    repeat (1000) @(posedge clk);
    #1;
    total++; if (got.size() != 0 || done_cnt != 0) $display("FAIL async_pending_cleared: got %0d bytes %0d blocks expected 0 0", got.size(), done_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_random_ready();
    test_back_to_back();
    test_overrun();
    test_final_handshake();
    test_start_abort();
`ifdef BUFF_READER_CSUM_EN
    test_csum();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
